my_alu: RTL and testbench

MY_ALU -- requirements
Module: my_alu

---
 rtl/my_alu.sv | 129 ++++++++++++
 tb/tb_my_alu.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/my_alu.sv
// my_alu: 32-bit ALU with a single registered output stage (1-cycle latency,
// one operation per cycle). ADD/SUB use eight chained 4-bit carry-lookahead
// nibble adders whose carries are reported per nibble on c_o.
// Optional feature macro: MY_ALU_SLT_EN enables the signed set-less-than op
// (select 110); without it that code yields zero and no comparator is built.
module my_alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i1,
  input  logic [31:0] i2,
  input  logic [2:0]  select,
  input  logic [3:0]  c_in,
  output logic [31:0] out,
  output logic [7:0]  c_o
);

  localparam int DATA_W  = 32;
  localparam int NIBBLES = DATA_W / 4;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_SRL = 3'b111;

  // 4-bit carry-lookahead adder: returns {carry_out, sum[3:0]}.
  function automatic logic [4:0] cla4(input logic [3:0] a,
                                      input logic [3:0] b,
                                      input logic       cin);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | ((&p) & cin);
    return {c[4], p ^ c[3:0]};
  endfunction

  // Only carry-in bit 0 has meaning; the upper bits are deliberately dropped.
  logic unused_cin;
  assign unused_cin = ^c_in[3:1];

  logic              sub_op;
  logic [DATA_W-1:0] b_op;
  logic [DATA_W-1:0] sum_p0;
  logic [NIBBLES-1:0] nib_co_p0;
  logic [DATA_W-1:0] res_p0;
  logic [NIBBLES-1:0] co_p0;
  logic [DATA_W-1:0] out_p1;
  logic [NIBBLES-1:0] c_o_p1;

`ifdef MY_ALU_SLT_EN
  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;
  logic                     lt;
  assign a_s = i1;
  assign b_s = i2;
  assign lt  = (a_s < b_s);
`endif

  // SUB reuses the adder as i1 + ~i2 + 1.
  assign sub_op = (select == OP_SUB);
  assign b_op   = sub_op ? ~i2 : i2;

  // Ripple the carry through the eight lookahead nibbles.
  always_comb begin : nibble_chain
    logic       cy;
    logic [4:0] nib;
    sum_p0    = '0;
    nib_co_p0 = '0;
    nib       = '0;
    cy        = sub_op ? 1'b1 : c_in[0];
    for (int k = 0; k < NIBBLES; k++) begin
      nib              = cla4(i1[4*k +: 4], b_op[4*k +: 4], cy);
      sum_p0[4*k +: 4] = nib[3:0];
      nib_co_p0[k]     = nib[4];
      cy               = nib[4];
    end
  end

  // Operation select; only ADD and SUB report carries.
  always_comb begin
    res_p0 = '0;
    co_p0  = '0;
    case (select)
      OP_AND: res_p0 = i1 & i2;
      OP_OR:  res_p0 = i1 | i2;
      OP_XOR: res_p0 = i1 ^ i2;
      OP_NOR: res_p0 = ~(i1 | i2);
      OP_ADD, OP_SUB: begin
        res_p0 = sum_p0;
        co_p0  = nib_co_p0;
      end
      OP_SLT: begin
`ifdef MY_ALU_SLT_EN
        res_p0 = {{(DATA_W-1){1'b0}}, lt};
`else
        res_p0 = '0;
`endif
      end
      OP_SRL: res_p0 = i1 >> i2[4:0];
      default: res_p0 = '0;
    endcase
  end

  // p0 -> p1 boundary: result register, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_p1 <= '0;
      c_o_p1 <= '0;
    end else begin
      out_p1 <= res_p0;
      c_o_p1 <= co_p0;
    end
  end

  assign out = out_p1;
  assign c_o = c_o_p1;

endmodule

// File: tb/tb_my_alu.sv
// tb_my_alu: scoreboard bench for my_alu. Stimulus pushes the expected
// result for each issued operation; a monitor pops and compares one cycle
// later. Random operations are checked against an arithmetic reference model.
module tb_my_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] i1;
  logic [31:0] i2;
  logic [2:0]  select;
  logic [3:0]  c_in;
  logic [31:0] out;
  logic [7:0]  c_o;

  typedef struct packed {
    logic [31:0] out;
    logic [7:0]  co;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   opn      = 0;

  my_alu dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .i1     (i1),
    .i2     (i2),
    .select (select),
    .c_in   (c_in),
    .out    (out),
    .c_o    (c_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] ao, input logic [7:0] ac,
                       input logic [31:0] eo, input logic [7:0] ec);
    n_checks++;
    if (ao !== eo || ac !== ec) begin
      n_fail++;
      $display("FAIL %s: got out=%h c_o=%h, required out=%h c_o=%h", name, ao, ac, eo, ec);
    end
  endtask

  // Reference model: plain arithmetic on the operation definitions.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] sel, input logic [3:0] ci);
    exp_t            e;
    longint unsigned m;
    longint unsigned al;
    longint unsigned bl;
    e.out = '0;
    e.co  = '0;
    case (sel)
      3'd0: e.out = a & b;
      3'd1: e.out = a | b;
      3'd3: e.out = a ^ b;
      3'd4: e.out = ~(a | b);
      3'd2: begin
        e.out = a + b + {31'd0, ci[0]};
        for (int k = 0; k < 8; k++) begin
          m       = 64'd1 << (4 * k + 4);
          al      = {32'd0, a} % m;
          bl      = {32'd0, b} % m;
          e.co[k] = ((al + bl + {63'd0, ci[0]}) >= m);
        end
      end
      3'd5: begin
        e.out = a - b;
        for (int k = 0; k < 8; k++) begin
          m       = 64'd1 << (4 * k + 4);
          al      = {32'd0, a} % m;
          bl      = {32'd0, b} % m;
          e.co[k] = (al >= bl);
        end
      end
      3'd6: begin
`ifdef MY_ALU_SLT_EN
        e.out = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`else
        e.out = 32'd0;
`endif
      end
      default: e.out = a >> b[4:0];
    endcase
    return e;
  endfunction

  // Issue one operation at the falling edge; optionally wiggle inputs first.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] sel,
                       input logic [3:0] ci, input logic [31:0] eo, input logic [7:0] ec,
                       input bit glitch);
    exp_t e;
    @(negedge clk);
    if (glitch) begin
      i1     = $urandom;
      i2     = $urandom;
      select = 3'($urandom);
      c_in   = 4'($urandom);
      #2;
    end
    i1     = a;
    i2     = b;
    select = sel;
    c_in   = ci;
    e.out  = eo;
    e.co   = ec;
    q.push_back(e);
  endtask

  task automatic issue_rand(input logic [31:0] a, input logic [31:0] b, input logic [2:0] sel,
                            input logic [3:0] ci, input bit glitch);
    exp_t e;
    e = model(a, b, sel, ci);
    issue(a, b, sel, ci, e.out, e.co, glitch);
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] corners [5];
    corners[0] = 32'h00000000;
    corners[1] = 32'hFFFFFFFF;
    corners[2] = 32'h80000000;
    corners[3] = 32'h7FFFFFFF;
    corners[4] = 32'h00000001;
    if ($urandom_range(0, 4) == 0) return corners[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  // Monitor: one result per issued operation, sampled after the rising edge.
  initial begin
    forever begin
      exp_t e;
      @(posedge clk);
      #1;
      if (rst_n && q.size() > 0) begin
        e = q.pop_front();
        check($sformatf("op%0d", opn), out, c_o, e.out, e.co);
        opn++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, required < 200000", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  s;
    int          waited;

    rst_n  = 1'b0;
    i1     = '0;
    i2     = '0;
    select = '0;
    c_in   = '0;
    #1;
    check("reset_state", out, c_o, 32'h0, 8'h0);
    @(posedge clk);
    #1;
    check("reset_held_over_edge", out, c_o, 32'h0, 8'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    issue(32'h10001001, 32'h00101000, 3'b000, 4'h0, 32'h00001000, 8'h00, 1'b0);
    issue(32'h10001001, 32'h00101000, 3'b001, 4'h0, 32'h10101001, 8'h00, 1'b0);
    issue(32'h10001001, 32'h00101000, 3'b011, 4'h0, 32'h10100001, 8'h00, 1'b0);
    issue(32'h10001001, 32'h00101000, 3'b100, 4'h0, 32'hEFEFEFFE, 8'h00, 1'b0);
    issue(32'h10001001, 32'h00101000, 3'b010, 4'h0, 32'h10102001, 8'h00, 1'b0);
    issue(32'h10001001, 32'h00101000, 3'b101, 4'h0, 32'h0FF00001, 8'h9F, 1'b0);
    issue(32'hFFFFFFFF, 32'h00000001, 3'b010, 4'h0, 32'h00000000, 8'hFF, 1'b0);
    issue(32'hFFFFFFFF, 32'h00000001, 3'b010, 4'h1, 32'h00000001, 8'hFF, 1'b0);
    issue(32'hFFFFFFFF, 32'h00000000, 3'b010, 4'hE, 32'hFFFFFFFF, 8'h00, 1'b0);
`ifdef MY_ALU_SLT_EN
    issue(32'hFFFFFFFF, 32'h00000001, 3'b110, 4'h0, 32'h00000001, 8'h00, 1'b0);
`else
    issue(32'hFFFFFFFF, 32'h00000001, 3'b110, 4'h0, 32'h00000000, 8'h00, 1'b0);
`endif
    issue(32'h10001001, 32'h00101000, 3'b110, 4'h0, 32'h00000000, 8'h00, 1'b0);
    issue(32'h80000000, 32'h0000001F, 3'b111, 4'h0, 32'h00000001, 8'h00, 1'b0);
    issue(32'hDEADBEEF, 32'hFFFFFFE0, 3'b111, 4'h0, 32'hDEADBEEF, 8'h00, 1'b1);

    // Asynchronous reset after a nonzero result
    issue(32'h10001001, 32'h00101000, 3'b001, 4'h0, 32'h10101001, 8'h00, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_out", out, c_o, 32'h0, 8'h0);

    // Reset mid-operation discards the pending result
    @(negedge clk);
    rst_n  = 1'b1;
    i1     = 32'hFFFFFFFF;
    i2     = 32'h00000001;
    select = 3'b010;
    c_in   = 4'h0;
    @(posedge clk);
    #1;
    check("nonzero_before_midop_reset", out, c_o, 32'h00000000, 8'hFF);
    @(negedge clk);
    i1 = 32'h12345678;
    i2 = 32'h11111111;
    #2;
    rst_n = 1'b0;
    #1;
    check("midop_reset_immediate", out, c_o, 32'h0, 8'h0);
    @(posedge clk);
    #1;
    check("midop_reset_discard", out, c_o, 32'h0, 8'h0);

    // First edge after release registers the operation then present
    @(negedge clk);
    rst_n  = 1'b1;
    i1     = 32'h0000000F;
    i2     = 32'h00000001;
    select = 3'b010;
    c_in   = 4'h0;
    q.push_back(model(32'h0000000F, 32'h00000001, 3'b010, 4'h0));

    // Randomized operations
    for (int n = 0; n < 400; n++) begin
      a = pick_operand();
      b = ($urandom_range(0, 9) == 0) ? a : pick_operand();
      s = 3'($urandom);
      if ($urandom_range(0, 7) == 0) @(negedge clk);
      issue_rand(a, b, s, 4'($urandom), ($urandom_range(0, 3) == 0));
    end

    // Drain the scoreboard within a bounded number of cycles
    waited = 0;
    while (q.size() > 0 && waited < 10) begin
      @(posedge clk);
      #2;
      waited++;
    end
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending results, required 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
